// File: rtl/useq_ctrl.sv
// useq_ctrl: next-address controller for a 12-bit Am2909-slice microsequencer.
// It decodes an Am2910-style opcode and a condition test into the slice controls.
// It also keeps the loop counter and a logical stack-depth tracker with sticky error flags.
module useq_ctrl #(
  parameter int CTR_WIDTH   = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [3:0]           instr,
  input  logic                 cc_n,
  input  logic                 ccen_n,
  input  logic                 hold,
  input  logic [CTR_WIDTH-1:0] d,
  output logic                 s1,
  output logic                 s0,
  output logic                 fe_n,
  output logic                 pup,
  output logic                 zero_n,
  output logic                 cin,
  output logic                 pl_n,
  output logic                 map_n,
  output logic                 vect_n,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 ctr_zero
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  // Slice source select encodings
  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  // Opcodes
  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic       pass_s;
  logic [1:0] src_s;
  logic       push_req_s, pop_req_s, zero_req_s;
  logic       map_s, vect_s;
  logic       ld_s, dec_s, clr_s;
  logic       push_ok_s, pop_ok_s;

  assign pass_s    = ccen_n | ~cc_n;
  assign ctr_zero  = (ctr_q == {CTR_WIDTH{1'b0}});
  assign full      = (depth_q == DEPTH_MAX);
  assign empty     = (depth_q == {DW{1'b0}});
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign push_ok_s = push_req_s & ~full;
  assign pop_ok_s  = pop_req_s & ~empty;

  // Opcode decode: raw source, stack request and counter action before guards
  always_comb begin
    src_s      = SRC_PC;
    push_req_s = 1'b0;
    pop_req_s  = 1'b0;
    zero_req_s = 1'b0;
    map_s      = 1'b0;
    vect_s     = 1'b0;
    ld_s       = 1'b0;
    dec_s      = 1'b0;
    clr_s      = 1'b0;
    case (instr)
      OP_JZ: begin
        zero_req_s = 1'b1;
        clr_s      = 1'b1;
      end
      OP_CJS: begin
        if (pass_s) begin
          src_s      = SRC_D;
          push_req_s = 1'b1;
        end else begin
          src_s = SRC_PC;
        end
      end
      OP_JMAP: begin
        src_s = SRC_D;
        map_s = 1'b1;
      end
      OP_CJP: begin
        src_s = pass_s ? SRC_D : SRC_PC;
      end
      OP_PUSH: begin
        push_req_s = 1'b1;
        ld_s       = pass_s;
      end
      OP_JSRP: begin
        src_s      = pass_s ? SRC_D : SRC_AR;
        push_req_s = 1'b1;
      end
      OP_CJV: begin
        if (pass_s) begin
          src_s  = SRC_D;
          vect_s = 1'b1;
        end else begin
          src_s = SRC_PC;
        end
      end
      OP_JRP: begin
        src_s = pass_s ? SRC_D : SRC_AR;
      end
      OP_RFCT: begin
        if (!ctr_zero) begin
          src_s = SRC_STK;
          dec_s = 1'b1;
        end else begin
          pop_req_s = 1'b1;
        end
      end
      OP_RPCT: begin
        if (!ctr_zero) begin
          src_s = SRC_D;
          dec_s = 1'b1;
        end else begin
          src_s = SRC_PC;
        end
      end
      OP_CRTN: begin
        if (pass_s) begin
          src_s     = SRC_STK;
          pop_req_s = 1'b1;
        end else begin
          src_s = SRC_PC;
        end
      end
      OP_CJPP: begin
        if (pass_s) begin
          src_s     = SRC_D;
          pop_req_s = 1'b1;
        end else begin
          src_s = SRC_PC;
        end
      end
      OP_LDCT: begin
        ld_s = 1'b1;
      end
      OP_LOOP: begin
        if (pass_s) begin
          pop_req_s = 1'b1;
        end else begin
          src_s = SRC_STK;
        end
      end
      OP_CONT: begin
        src_s = SRC_PC;
      end
      OP_TWB: begin
        if (pass_s) begin
          pop_req_s = 1'b1;
        end else if (!ctr_zero) begin
          src_s = SRC_STK;
          dec_s = 1'b1;
        end else begin
          src_s     = SRC_D;
          pop_req_s = 1'b1;
        end
      end
      default: begin
        src_s = SRC_PC;
      end
    endcase
  end

  // Slice control outputs: reset forces a load of zero, hold recirculates the microPC
  always_comb begin
    {s1, s0} = SRC_PC;
    fe_n     = 1'b1;
    pup      = 1'b0;
    zero_n   = 1'b1;
    cin      = 1'b1;
    pl_n     = 1'b0;
    map_n    = 1'b1;
    vect_n   = 1'b1;
    if (!reset_n) begin
      zero_n = 1'b0;
      cin    = 1'b0;
    end else if (hold) begin
      cin = 1'b0;
    end else begin
      {s1, s0} = src_s;
      zero_n   = ~zero_req_s;
      fe_n     = ~(push_ok_s | pop_ok_s);
      pup      = push_ok_s;
      pl_n     = map_s | vect_s;
      map_n    = ~map_s;
      vect_n   = ~vect_s;
    end
  end

  // Next state of counter, depth and sticky flags; hold freezes everything
  always_comb begin
    ctr_d   = ctr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!hold) begin
      if (ld_s) begin
        ctr_d = d;
      end else if (dec_s && !ctr_zero) begin
        ctr_d = ctr_q - CTR_WIDTH'(1);
      end else begin
        ctr_d = ctr_q;
      end
      if (clr_s) begin
        depth_d = {DW{1'b0}};
      end else if (push_ok_s) begin
        depth_d = depth_q + DW'(1);
      end else if (pop_ok_s) begin
        depth_d = depth_q - DW'(1);
      end else begin
        depth_d = depth_q;
      end
      ovf_d = ovf_q | (push_req_s & full);
      unf_d = unf_q | (pop_req_s & empty);
    end else begin
      ctr_d = ctr_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctr_q   <= {CTR_WIDTH{1'b0}};
      depth_q <= {DW{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ctr_q   <= ctr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: directed bench for useq_ctrl with a small Am2909 slice model
// that turns the decoded controls into a microPC trace.
module tb_useq_ctrl;

  logic        clock;
  logic        reset_n;
  logic [3:0]  instr;
  logic        cc_n;
  logic        ccen_n;
  logic        hold;
  logic [11:0] d;
  logic        s1, s0, fe_n, pup, zero_n, cin, pl_n, map_n, vect_n;
  logic        full, empty, overflow, underflow, ctr_zero;

  int n_total = 0;
  int n_bad   = 0;

  useq_ctrl #(.CTR_WIDTH(12), .STACK_DEPTH(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .instr    (instr),
    .cc_n     (cc_n),
    .ccen_n   (ccen_n),
    .hold     (hold),
    .d        (d),
    .s1       (s1),
    .s0       (s0),
    .fe_n     (fe_n),
    .pup      (pup),
    .zero_n   (zero_n),
    .cin      (cin),
    .pl_n     (pl_n),
    .map_n    (map_n),
    .vect_n   (vect_n),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow),
    .ctr_zero (ctr_zero)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slice model: microPC, address register and a 4-word stack
  logic [11:0] upc_m;
  logic [11:0] ar_m;
  logic [11:0] stk_m [4];
  int          sp_m;
  logic [11:0] y_m;
  logic [1:0]  top_idx;

  assign ar_m    = 12'h0AA;
  assign top_idx = 2'(sp_m - 1);

  // Slice output mux
  always_comb begin
    y_m = upc_m;
    if (!zero_n) begin
      y_m = 12'h000;
    end else begin
      case ({s1, s0})
        2'b00:   y_m = upc_m;
        2'b01:   y_m = ar_m;
        2'b10:   y_m = stk_m[top_idx];
        default: y_m = d;
      endcase
    end
  end

  // Slice registers capture on the rising edge
  always @(posedge clock) begin
    upc_m <= y_m + {11'd0, cin};
    if (!reset_n) begin
      sp_m <= 0;
    end else if (!fe_n) begin
      if (pup) begin
        stk_m[sp_m[1:0]] <= upc_m;
        sp_m <= sp_m + 1;
      end else begin
        sp_m <= sp_m - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] op, input logic ccn, input logic [11:0] dv);
    instr = op;
    cc_n  = ccn;
    d     = dv;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    instr   = 4'd14;
    cc_n    = 1'b1;
    ccen_n  = 1'b0;
    hold    = 1'b0;
    d       = 12'h000;
    tick();
    tick();

    // Reset state
    check("rst_zero_n", 32'(zero_n), 32'd0);
    check("rst_cin", 32'(cin), 32'd0);
    check("rst_fe_n", 32'(fe_n), 32'd1);
    check("rst_src", 32'({s1, s0}), 32'd0);
    check("rst_pl_n", 32'(pl_n), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ctr_zero", 32'(ctr_zero), 32'd1);
    check("rst_upc", 32'(upc_m), 32'd0);
    reset_n = 1'b1;

    // CONT x3 then two more to reach PC 5
    for (int i = 1; i <= 5; i++) begin
      apply(4'd14, 1'b1, 12'h000);
      tick();
      if (i <= 3) check("cont_upc", 32'(upc_m), 32'(i));
    end
    check("cont_empty", 32'(empty), 32'd1);
    check("cont_ctr_zero", 32'(ctr_zero), 32'd1);
    check("pc5", 32'(upc_m), 32'h5);

    // CJS pass to 0x100, then CRTN back
    apply(4'd1, 1'b0, 12'h100);
    check("cjs_src", 32'({s1, s0}), 32'd3);
    check("cjs_fe_pup", 32'({fe_n, pup}), 32'b01);
    tick();
    check("cjs_upc", 32'(upc_m), 32'h101);
    check("cjs_depth", 32'(dut.depth_q), 32'd1);
    apply(4'd10, 1'b0, 12'h000);
    check("crtn_src", 32'({s1, s0}), 32'd2);
    check("crtn_fe_pup", 32'({fe_n, pup}), 32'b00);
    tick();
    check("crtn_upc", 32'(upc_m), 32'h6);
    check("crtn_empty", 32'(empty), 32'd1);

    // JMAP and CJV D-bus enables (combinational only)
    apply(4'd2, 1'b1, 12'h000);
    check("jmap_en", 32'({pl_n, map_n, vect_n}), 32'b101);
    apply(4'd6, 1'b0, 12'h000);
    check("cjv_en", 32'({pl_n, map_n, vect_n}), 32'b110);
    apply(4'd6, 1'b1, 12'h000);
    check("cjv_fail", 32'({s1, s0, pl_n}), 32'b000);

    // LDCT 2 then RPCT x3
    apply(4'd12, 1'b1, 12'd2);
    tick();
    check("ldct_ctr", 32'(dut.ctr_q), 32'd2);
    check("ldct_upc", 32'(upc_m), 32'h7);
    apply(4'd9, 1'b1, 12'h040);
    tick();
    check("rpct1_upc", 32'(upc_m), 32'h041);
    check("rpct1_ctr", 32'(dut.ctr_q), 32'd1);
    tick();
    check("rpct2_upc", 32'(upc_m), 32'h041);
    check("rpct2_ctr", 32'(dut.ctr_q), 32'd0);
    check("rpct3_src", 32'({s1, s0}), 32'd0);
    tick();
    check("rpct3_upc", 32'(upc_m), 32'h042);
    check("rpct3_ctr_zero", 32'(ctr_zero), 32'd1);
    check("rpct3_unf", 32'(underflow), 32'd0);

    // Five CJS: fill the stack, fifth overflows
    for (int i = 1; i <= 4; i++) begin
      apply(4'd1, 1'b0, 12'h200);
      tick();
    end
    check("fill_depth", 32'(dut.depth_q), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    apply(4'd1, 1'b0, 12'h200);
    check("ovf_fe_n", 32'(fe_n), 32'd1);
    check("ovf_src", 32'({s1, s0}), 32'd3);
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_depth", 32'(dut.depth_q), 32'd4);
    for (int i = 0; i < 10; i++) begin
      apply(4'd14, 1'b1, 12'h000);
      tick();
    end
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_upc", 32'(upc_m), 32'h20B);

    // JZ clears depth, CRTN at empty underflows
    apply(4'd0, 1'b1, 12'h000);
    check("jz_zero_n", 32'(zero_n), 32'd0);
    tick();
    check("jz_upc", 32'(upc_m), 32'h1);
    check("jz_empty", 32'(empty), 32'd1);
    apply(4'd10, 1'b0, 12'h000);
    check("unf_fe_n", 32'(fe_n), 32'd1);
    check("unf_src", 32'({s1, s0}), 32'd2);
    tick();
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_depth", 32'(dut.depth_q), 32'd0);

    // Hold: microPC, counter and depth frozen
    apply(4'd3, 1'b0, 12'h0FF);
    tick();
    check("cjp_upc", 32'(upc_m), 32'h100);
    hold = 1'b1;
    apply(4'd4, 1'b0, 12'd5);
    check("hold_ctl", 32'({s1, s0, cin, fe_n, zero_n}), 32'b00011);
    for (int i = 0; i < 3; i++) tick();
    check("hold_upc", 32'(upc_m), 32'h100);
    check("hold_ctr", 32'(dut.ctr_q), 32'd0);
    check("hold_depth", 32'(dut.depth_q), 32'd0);
    hold = 1'b0;

    // Build an RFCT loop with ctr 7, depth 2, then reset mid-loop
    apply(4'd1, 1'b0, 12'h300);
    tick();
    apply(4'd1, 1'b0, 12'h300);
    tick();
    apply(4'd12, 1'b1, 12'd7);
    tick();
    check("loop_depth", 32'(dut.depth_q), 32'd2);
    check("loop_ctr", 32'(dut.ctr_q), 32'd7);
    apply(4'd8, 1'b1, 12'h000);
    check("rfct_src", 32'({s1, s0}), 32'd2);
    check("rfct_fe_n", 32'(fe_n), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_ctr", 32'(dut.ctr_q), 32'd0);
    check("arst_depth", 32'(dut.depth_q), 32'd0);
    check("arst_zero_n", 32'(zero_n), 32'd0);
    check("arst_flags", 32'({overflow, underflow}), 32'd0);
    tick();
    check("arst_upc", 32'(upc_m), 32'd0);
    reset_n = 1'b1;

    // RFCT with counter at zero pops; TWB at zero with fail goes to D
    apply(4'd1, 1'b0, 12'h050);
    tick();
    apply(4'd8, 1'b1, 12'h000);
    check("rfct0_ctl", 32'({s1, s0, fe_n, pup}), 32'b0000);
    tick();
    check("rfct0_depth", 32'(dut.depth_q), 32'd0);
    apply(4'd1, 1'b0, 12'h060);
    tick();
    ccen_n = 1'b0;
    apply(4'd15, 1'b1, 12'h0C0);
    check("twb0_ctl", 32'({s1, s0, fe_n, pup}), 32'b1100);
    tick();
    check("twb0_upc", 32'(upc_m), 32'h0C1);
    check("twb0_depth", 32'(dut.depth_q), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
